// File: rtl/dhm_pwr_seq_if.sv
// -----------------------------------------------------------------------------
// dhm_pwr_seq_if
//
// Purpose : Groups the control and status signals between the power/retention
//           sequencer and its surroundings (request logic, datapath idle
//           detect, power switch, and the gated core's retention/reset pins).
//
// Signals :
//   req_sleep        level request to power the domain down
//   req_wake         level request to power the domain up
//   dp_idle          datapath holds no in-flight data
//   sleep_ack        power switch acknowledge, asynchronous to clk
//   err_clr          clears the sticky ack-timeout flag
//   blk_in           blocks upstream traffic while the domain is not ON
//   pd_reset_n       domain reset, active low
//   rreg_save(_n)    retention save strobe and complement
//   rreg_restore(_n) retention restore strobe and complement
//   sleep(_n)        power-gate request and complement
//   pwr_up           high only while the domain is fully ON
//   state            current sequencer state encoding
//   err              sticky ack-timeout flag
//
// Modports:
//   master : the environment; drives requests, idle, ack and err_clr
//   slave  : the sequencer; drives the power/retention controls and status
// -----------------------------------------------------------------------------
interface dhm_pwr_seq_if;
    logic       req_sleep;
    logic       req_wake;
    logic       dp_idle;
    logic       sleep_ack;
    logic       err_clr;

    logic       blk_in;
    logic       pd_reset_n;
    logic       rreg_save;
    logic       rreg_save_n;
    logic       rreg_restore;
    logic       rreg_restore_n;
    logic       sleep;
    logic       sleep_n;
    logic       pwr_up;
    logic [2:0] state;
    logic       err;

    modport master (
        output req_sleep, req_wake, dp_idle, sleep_ack, err_clr,
        input  blk_in, pd_reset_n, rreg_save, rreg_save_n,
               rreg_restore, rreg_restore_n, sleep, sleep_n,
               pwr_up, state, err
    );

    modport slave (
        input  req_sleep, req_wake, dp_idle, sleep_ack, err_clr,
        output blk_in, pd_reset_n, rreg_save, rreg_save_n,
               rreg_restore, rreg_restore_n, sleep, sleep_n,
               pwr_up, state, err
    );
endinterface

// File: rtl/dhm_pwr_seq.sv
// -----------------------------------------------------------------------------
// dhm_pwr_seq
//
// Purpose : Power/retention sequencer for the power-gated DES datapath core.
//           Going down it drains in-flight traffic, pulses retention save and
//           requests power gating, then holds the domain in reset while off.
//           Coming up it ungates power, pulses retention restore and releases
//           the domain reset.
//
// Ports   :
//   clk      core clock
//   reset_n  asynchronous active-low reset (lands in RELEASE, as a cold boot)
//   bus      dhm_pwr_seq_if.slave -- requests, idle, switch ack, err_clr in;
//            blk_in, pd_reset_n, retention strobes, sleep, pwr_up, state,
//            err out
//
// Parameters:
//   SAVE_CYC    cycles rreg_save is held high            (1..2^CW-1)
//   RESTORE_CYC cycles rreg_restore is held high         (1..2^CW-1)
//   RST_CYC     cycles pd_reset_n is held low in RELEASE (1..2^CW-1)
//   ACK_TIMEOUT cycles to wait for synchronized ack      (1..2^CW-1)
//   CW          width of the shared down-counter
// -----------------------------------------------------------------------------
module dhm_pwr_seq #(
    parameter int SAVE_CYC    = 4,
    parameter int RESTORE_CYC = 4,
    parameter int RST_CYC     = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    dhm_pwr_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_SAVE    = 3'd2,
        ST_PGATE   = 3'd3,
        ST_OFF     = 3'd4,
        ST_UNGATE  = 3'd5,
        ST_RESTORE = 3'd6,
        ST_RELEASE = 3'd7
    } state_t;

    // A timed state is entered with N-1 and leaves on the edge where the
    // counter reads zero, so it lasts exactly N cycles.
    localparam logic [CW-1:0] SAVE_LD    = CW'(SAVE_CYC - 1);
    localparam logic [CW-1:0] RESTORE_LD = CW'(RESTORE_CYC - 1);
    localparam logic [CW-1:0] RST_LD     = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] ACK_LD     = CW'(ACK_TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // sleep_ack synchronizer
    // -------------------------------------------------------------------------
    logic ack_m;
    logic ack_s;

    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop, independent of
    // the order the simulator evaluates the processes in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= bus.sleep_ack;
            ack_s <= ack_m;
        end
    end

    // -------------------------------------------------------------------------
    // State, counter and error register
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            timeout;
    logic            cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RELEASE;
            cnt_q   <= RST_LD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        timeout = 1'b0;

        case (state_q)
            ST_ON: begin
                // A wake request arriving together with sleep is meaningless
                // here; the domain is already up.
                if (bus.req_sleep) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Wake aborts the power-down before anything is saved.
                if (bus.req_wake) begin
                    state_d = ST_ON;
                end else if (bus.dp_idle) begin
                    state_d = ST_SAVE;
                    cnt_d   = SAVE_LD;
                end
            end

            ST_SAVE: begin
                if (cnt_zero) begin
                    state_d = ST_PGATE;
                    cnt_d   = ACK_LD;
                end
            end

            ST_PGATE: begin
                // An ack on the final cycle still counts as a clean handshake.
                if (ack_s) begin
                    state_d = ST_OFF;
                end else if (cnt_zero) begin
                    state_d = ST_OFF;
                    timeout = 1'b1;
                end
            end

            ST_OFF: begin
                if (bus.req_wake) begin
                    state_d = ST_UNGATE;
                    cnt_d   = ACK_LD;
                end
            end

            ST_UNGATE: begin
                if (!ack_s) begin
                    state_d = ST_RESTORE;
                    cnt_d   = RESTORE_LD;
                end else if (cnt_zero) begin
                    state_d = ST_RESTORE;
                    cnt_d   = RESTORE_LD;
                    timeout = 1'b1;
                end
            end

            ST_RESTORE: begin
                if (cnt_zero) begin
                    state_d = ST_RELEASE;
                    cnt_d   = RST_LD;
                end
            end

            ST_RELEASE: begin
                if (cnt_zero) begin
                    state_d = ST_ON;
                end
            end
        endcase

        // A timeout on the same cycle as err_clr wins so the event is not lost.
        if (timeout) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and never glitch. Each complement is its
    // own flop with the inverted reset value; a pair can never read equal.
    logic pd_reset_n_q, blk_in_q, pwr_up_q;
    logic save_q, save_n_q, restore_q, restore_n_q, sleep_q, sleep_n_q;

    logic pd_reset_n_d, blk_in_d, pwr_up_d, save_d, restore_d, sleep_d;

    always_comb begin
        // The domain stays out of reset until it has actually been gated.
        pd_reset_n_d = (state_d == ST_ON)   || (state_d == ST_DRAIN) ||
                       (state_d == ST_SAVE) || (state_d == ST_PGATE);
        blk_in_d     = (state_d != ST_ON);
        pwr_up_d     = (state_d == ST_ON);
        save_d       = (state_d == ST_SAVE);
        restore_d    = (state_d == ST_RESTORE);
        sleep_d      = (state_d == ST_PGATE) || (state_d == ST_OFF);
    end

    // NOTE: every output flop has an explicit asynchronous reset value so the
    // gated core sees a defined, safe level the instant reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pd_reset_n_q <= 1'b0;
            blk_in_q     <= 1'b1;
            pwr_up_q     <= 1'b0;
            save_q       <= 1'b0;
            save_n_q     <= 1'b1;
            restore_q    <= 1'b0;
            restore_n_q  <= 1'b1;
            sleep_q      <= 1'b0;
            sleep_n_q    <= 1'b1;
        end else begin
            pd_reset_n_q <= pd_reset_n_d;
            blk_in_q     <= blk_in_d;
            pwr_up_q     <= pwr_up_d;
            save_q       <= save_d;
            save_n_q     <= ~save_d;
            restore_q    <= restore_d;
            restore_n_q  <= ~restore_d;
            sleep_q      <= sleep_d;
            sleep_n_q    <= ~sleep_d;
        end
    end

    assign bus.pd_reset_n     = pd_reset_n_q;
    assign bus.blk_in         = blk_in_q;
    assign bus.pwr_up         = pwr_up_q;
    assign bus.rreg_save      = save_q;
    assign bus.rreg_save_n    = save_n_q;
    assign bus.rreg_restore   = restore_q;
    assign bus.rreg_restore_n = restore_n_q;
    assign bus.sleep          = sleep_q;
    assign bus.sleep_n        = sleep_n_q;
    assign bus.state          = state_q;
    assign bus.err            = err_q;

endmodule
